// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: owns the PC, issues in-order word requests under a
// credit limit, and buffers PC-tagged responses in a FIFO toward decode.
module instr_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef logic [AW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] rsp_pc_q, rsp_pc_d;
   ptr_t        wr_ptr_q, wr_ptr_d;
   ptr_t        rd_ptr_q, rd_ptr_d;
   cnt_t        count_q, count_d;
   cnt_t        outstanding_q, outstanding_d;
   cnt_t        discard_q, discard_d;

   logic [31:0] pc_mem    [DEPTH];
   logic [31:0] instr_mem [DEPTH];

   logic        credit_ok;
   logic        req_fire;
   logic        pop;
   logic        rsp_ok;
   logic        push;
   logic [31:0] redirect_aligned;

   // Credit covers both buffered entries and in-flight requests, so a response never overflows.
   assign credit_ok        = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_W;
   assign imem_req_valid   = !rst && !redirect_valid && credit_ok;
   assign imem_req_addr    = fetch_pc_q;
   assign id_valid         = !rst && !redirect_valid && (count_q != '0);
   assign id_instr         = instr_mem[rd_ptr_q];
   assign id_pc            = pc_mem[rd_ptr_q];

   assign req_fire         = imem_req_valid && imem_req_ready;
   assign pop              = id_valid && id_ready;
   assign rsp_ok           = imem_rsp_valid && (outstanding_q != '0);
   assign push             = rsp_ok && (discard_q == '0) && !redirect_valid;
   assign redirect_aligned = {redirect_pc[31:2], 2'b00};

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(rsp_ok);
      discard_d     = discard_q;

      if (redirect_valid) begin
         // The response arriving this cycle is itself dropped, so it leaves the discard budget.
         fetch_pc_d = redirect_aligned;
         rsp_pc_d   = redirect_aligned;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         discard_d  = outstanding_q - cnt_t'(rsp_ok);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (rsp_ok && (discard_q != '0)) discard_d = discard_q - cnt_t'(1);
         if (push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
         count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   // NOTE: storage is not reset; entries are only read once count_q marks them written.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= rsp_pc_q;
         instr_mem[wr_ptr_q] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: streaming, backpressure, redirects, PC wrap
// and mid-operation reset, with a bench-side memory that answers in request order.
module tb_instr_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   int          passed = 0;
   int          total  = 0;
   logic [31:0] req_q [$];

   instr_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc)
   );

   always #5 clk = ~clk;

   // Record accepted requests, cross the edge, then clear single-cycle pulses.
   task automatic tick();
      #1;
      if (imem_req_valid && imem_req_ready) req_q.push_back(imem_req_addr);
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
   endtask

   // Memory model: the word at address a is a + 0x13.
   task automatic drive_rsp();
      logic [31:0] a;
      if (req_q.size() > 0) begin
         a              = req_q.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = a + 32'h13;
      end
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      tick();
      rst = 1'b0;
      req_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); else passed++;
      total++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid got %b exp 0", id_valid); else passed++;
      tick();
      rst = 1'b0;
      #1;
      total++; if (imem_req_valid !== 1'b1) $display("FAIL post_reset_req_valid got %b exp 1", imem_req_valid); else passed++;
      total++; if (imem_req_addr !== 32'h0) $display("FAIL post_reset_addr got %h exp 00000000", imem_req_addr); else passed++;
      total++; if (id_valid !== 1'b0) $display("FAIL post_reset_id_valid got %b exp 0", id_valid); else passed++;
   endtask

   task automatic test_stream();
      do_reset();
      for (int c = 0; c < 8; c++) begin
         drive_rsp();
         #1;
         total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4*c))
            $display("FAIL stream_req c=%0d got v=%b a=%h exp v=1 a=%h", c, imem_req_valid, imem_req_addr, 32'(4*c)); else passed++;
         if (c < 2) begin
            total++; if (id_valid !== 1'b0) $display("FAIL stream_no_bypass c=%0d got %b exp 0", c, id_valid); else passed++;
         end else begin
            total++; if (id_valid !== 1'b1 || id_pc !== 32'(4*(c-2)) || id_instr !== 32'(4*(c-2)) + 32'h13)
               $display("FAIL stream_id c=%0d got v=%b pc=%h i=%h exp pc=%h", c, id_valid, id_pc, id_instr, 32'(4*(c-2))); else passed++;
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      id_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drive_rsp();
         #1;
         total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4*c))
            $display("FAIL bp_req c=%0d got v=%b a=%h exp v=1 a=%h", c, imem_req_valid, imem_req_addr, 32'(4*c)); else passed++;
         tick();
      end
      drive_rsp();
      #1;
      total++; if (imem_req_valid !== 1'b0) $display("FAIL bp_credit_stop got %b exp 0", imem_req_valid); else passed++;
      tick();
      for (int c = 0; c < 2; c++) begin
         #1;
         total++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h0)
            $display("FAIL bp_full_hold c=%0d got rv=%b iv=%b pc=%h exp rv=0 iv=1 pc=00000000", c, imem_req_valid, id_valid, id_pc); else passed++;
         tick();
      end
      id_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive_rsp();
         #1;
         total++; if (id_valid !== 1'b1 || id_pc !== 32'(4*k) || id_instr !== 32'(4*k) + 32'h13)
            $display("FAIL bp_drain k=%0d got v=%b pc=%h i=%h exp pc=%h", k, id_valid, id_pc, id_instr, 32'(4*k)); else passed++;
         if (k == 0) begin
            total++; if (imem_req_valid !== 1'b0) $display("FAIL bp_no_req_on_pop got %b exp 0", imem_req_valid); else passed++;
         end
         if (k == 1) begin
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10)
               $display("FAIL bp_resume got v=%b a=%h exp v=1 a=00000010", imem_req_valid, imem_req_addr); else passed++;
         end
         tick();
      end
   endtask

   task automatic test_redirect_idle();
      do_reset();
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      #1;
      total++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0)
         $display("FAIL redir_cycle got rv=%b iv=%b exp 0 0", imem_req_valid, id_valid); else passed++;
      tick();
      drive_rsp();
      #1;
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100)
         $display("FAIL redir_new_addr got v=%b a=%h exp v=1 a=00000100", imem_req_valid, imem_req_addr); else passed++;
      tick();
      for (int c = 0; c < 2; c++) begin
         drive_rsp();
         #1;
         total++; if (id_valid !== 1'b0) $display("FAIL redir_dropped c=%0d got %b exp 0", c, id_valid); else passed++;
         tick();
      end
      drive_rsp();
      #1;
      total++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h113)
         $display("FAIL redir_first_id got v=%b pc=%h i=%h exp pc=00000100 i=00000113", id_valid, id_pc, id_instr); else passed++;
      tick();
   endtask

   task automatic test_redirect_with_rsp();
      do_reset();
      for (int c = 0; c < 3; c++) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h200;
      drive_rsp();
      #1;
      total++; if (imem_req_valid !== 1'b0) $display("FAIL redir2_cycle got %b exp 0", imem_req_valid); else passed++;
      tick();
      drive_rsp();
      #1;
      total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200)
         $display("FAIL redir2_new_addr got v=%b a=%h exp v=1 a=00000200", imem_req_valid, imem_req_addr); else passed++;
      tick();
      for (int c = 0; c < 2; c++) begin
         drive_rsp();
         #1;
         total++; if (id_valid !== 1'b0) $display("FAIL redir2_dropped c=%0d got %b exp 0", c, id_valid); else passed++;
         tick();
      end
      #1;
      total++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== 32'h213)
         $display("FAIL redir2_first_id got v=%b pc=%h i=%h exp pc=00000200 i=00000213", id_valid, id_pc, id_instr); else passed++;
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      #1;
      total++; if (imem_req_valid !== 1'b0) $display("FAIL wrap_redir_cycle got %b exp 0", imem_req_valid); else passed++;
      tick();
      #1;
      total++; if (imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0 got %h exp fffffffc", imem_req_addr); else passed++;
      tick();
      drive_rsp();
      #1;
      total++; if (imem_req_addr !== 32'h0) $display("FAIL wrap_addr1 got %h exp 00000000", imem_req_addr); else passed++;
      tick();
      drive_rsp();
      #1;
      total++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_instr !== 32'h0000_000F)
         $display("FAIL wrap_id0 got v=%b pc=%h i=%h exp pc=fffffffc i=0000000f", id_valid, id_pc, id_instr); else passed++;
      tick();
      drive_rsp();
      #1;
      total++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h13)
         $display("FAIL wrap_id1 got v=%b pc=%h i=%h exp pc=00000000 i=00000013", id_valid, id_pc, id_instr); else passed++;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      id_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 1 || c == 2) drive_rsp();
         tick();
      end
      rst = 1'b1;
      #1;
      total++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0)
         $display("FAIL mid_reset_cycle got rv=%b iv=%b exp 0 0", imem_req_valid, id_valid); else passed++;
      tick();
      rst            = 1'b0;
      imem_req_ready = 1'b0;
      drive_rsp();
      #1;
      total++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
         $display("FAIL mid_after_reset got iv=%b rv=%b a=%h exp iv=0 rv=1 a=00000000", id_valid, imem_req_valid, imem_req_addr); else passed++;
      tick();
      drive_rsp();
      #1;
      total++; if (id_valid !== 1'b0) $display("FAIL mid_late_rsp0 got %b exp 0", id_valid); else passed++;
      tick();
      imem_req_ready = 1'b1;
      #1;
      total++; if (id_valid !== 1'b0) $display("FAIL mid_late_rsp1 got %b exp 0", id_valid); else passed++;
      tick();
      imem_req_ready = 1'b0;
      drive_rsp();
      tick();
      #1;
      total++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h13)
         $display("FAIL mid_first_id got v=%b pc=%h i=%h exp pc=00000000 i=00000013", id_valid, id_pc, id_instr); else passed++;
      tick();
   endtask

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_idle();
      test_redirect_with_rsp();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
